// File: rtl/full_datapath_pkg.sv
// full_datapath_pkg: shared ALU op codes, opcode constants and XLEN for the RV32I datapath
package full_datapath_pkg;
   localparam int XLEN = 32;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_SLL  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SLTU = 4'd8,
      ALU_LUI  = 4'd9
   } alu_op_e;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
endpackage

// File: rtl/full_datapath_alu.sv
// full_datapath_alu: combinational RV32I ALU with Sign/Zero flags
module full_datapath_alu
   import full_datapath_pkg::*;
(
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y,
   output logic            sign,
   output logic            zero
);
   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_SLL:  y = a << b[4:0];
         ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
         ALU_XOR:  y = a ^ b;
         ALU_SRL:  y = a >> b[4:0];
         ALU_SLTU: y = {31'd0, a < b};
         ALU_LUI:  y = b;
         default:  y = '0;
      endcase
   end

   assign sign = y[XLEN-1];
   assign zero = (y == '0);
endmodule

// File: rtl/full_datapath_reg_file.sv
// full_datapath_reg_file: 32x32 register file, reset loads x[i]=i, x0 hardwired to zero
module full_datapath_reg_file
   import full_datapath_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] q1,
   output logic [XLEN-1:0] q2
);
   logic [XLEN-1:0] regs [32];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < 32; i++) regs[i] <= XLEN'(i);
      else if (we && wa != 5'd0)
         regs[wa] <= wd;

   assign q1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign q2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

// File: rtl/full_datapath.sv
// full_datapath: single-cycle RV32I datapath (PC, regfile, immgen, ALU, dmem, write-back)
// driven by externally supplied control signals and instruction word.
module full_datapath
   import full_datapath_pkg::*;
#(
   parameter int DMEM_WORDS = 256
) (
   input  logic        CLK,
   input  logic        ResetPC,
   input  logic [31:0] Instruction,
   input  logic        RegWrite,
   input  logic        ALUSrc,
   input  logic [3:0]  ALUControl,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic        MemToReg,
   input  logic        Branch,
   output logic        Sign,
   output logic        Zero
);
   localparam int AW = $clog2(DMEM_WORDS);

   logic [XLEN-1:0] pc, rs1_d, rs2_d, imm, imm_b, alu_b, alu_y, rdata, wb;
   logic [XLEN-1:0] dmem [DMEM_WORDS];
   logic [AW-1:0]   addr;
   logic [6:0]      opcode;

   assign opcode = Instruction[6:0];
   assign imm_b  = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                    Instruction[30:25], Instruction[11:8], 1'b0};

   always_comb
      imm = (opcode == OP_I || opcode == OP_LOAD) ? {{20{Instruction[31]}}, Instruction[31:20]} :
            (opcode == OP_STORE) ? {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]} :
            (opcode == OP_BRANCH) ? imm_b :
            (opcode == OP_LUI) ? {Instruction[31:12], 12'b0} : '0;

   full_datapath_reg_file u_rf (
      .clk(CLK), .rst_n(ResetPC), .we(RegWrite),
      .ra1(Instruction[19:15]), .ra2(Instruction[24:20]), .wa(Instruction[11:7]),
      .wd(wb), .q1(rs1_d), .q2(rs2_d)
   );

   assign alu_b = ALUSrc ? imm : rs2_d;

   full_datapath_alu u_alu (
      .op(ALUControl), .a(rs1_d), .b(alu_b), .y(alu_y), .sign(Sign), .zero(Zero)
   );

   // Low two address bits are dropped; the remaining index wraps with the depth.
   assign addr  = alu_y[AW+1:2];
   assign rdata = MemRead ? dmem[addr] : '0;
   assign wb    = MemToReg ? rdata : alu_y;

   always_ff @(posedge CLK)
      if (MemWrite) dmem[addr] <= rs2_d;

   always_ff @(posedge CLK or negedge ResetPC)
      if (!ResetPC) pc <= '0;
      else          pc <= pc + ((Branch && Zero) ? imm_b : 32'd4);
endmodule

// File: tb/tb_full_datapath.sv
// tb_full_datapath: directed-vector self-checking bench for full_datapath
module tb_full_datapath;
   import full_datapath_pkg::*;

   logic        CLK = 1'b0;
   logic        ResetPC;
   logic [31:0] Instruction;
   logic        RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
   logic [3:0]  ALUControl;
   logic        Sign, Zero;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_pc;

   full_datapath dut (
      .CLK(CLK), .ResetPC(ResetPC), .Instruction(Instruction), .RegWrite(RegWrite),
      .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemWrite(MemWrite), .MemRead(MemRead),
      .MemToReg(MemToReg), .Branch(Branch), .Sign(Sign), .Zero(Zero)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] r_ins(input logic [4:0] rd, rs1, rs2);
      return {7'b0, rs2, rs1, 3'b0, rd, OP_R};
   endfunction
   function automatic logic [31:0] i_ins(input logic [6:0] op, input logic [4:0] rd, rs1,
                                         input logic [11:0] imm);
      return {imm, rs1, 3'b010, rd, op};
   endfunction
   function automatic logic [31:0] s_ins(input logic [4:0] rs1, rs2, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
   endfunction
   function automatic logic [31:0] b_ins(input logic [4:0] rs1, rs2, input logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, 3'b0, imm[4:1], imm[11], OP_BRANCH};
   endfunction
   function automatic logic [31:0] u_ins(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, OP_LUI};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic rw, src, input logic [3:0] ctl,
                        input logic mw, mr, m2r, br);
      Instruction = ins; RegWrite = rw; ALUSrc = src; ALUControl = ctl;
      MemWrite = mw; MemRead = mr; MemToReg = m2r; Branch = br;
      #1;
   endtask

   task automatic tick(input logic [31:0] pc_inc);
      @(posedge CLK);
      #1;
      exp_pc = exp_pc + pc_inc;
      check("pc", dut.pc, exp_pc);
   endtask

   initial begin
      ResetPC = 1'b0;
      drive(32'h0, 0, 0, 4'd0, 0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      #1;
      exp_pc = 0;
      check("rst_pc", dut.pc, 32'd0);
      check("rst_x0", dut.u_rf.regs[0], 32'd0);
      check("rst_x1", dut.u_rf.regs[1], 32'd1);
      check("rst_x31", dut.u_rf.regs[31], 32'd31);
      check("rst_zero", {31'd0, Zero}, 32'd1);
      @(negedge CLK);
      ResetPC = 1'b1;

      drive(r_ins(1, 3, 2), 1, 0, ALU_ADD, 0, 0, 0, 0);
      check("add_zero", {31'd0, Zero}, 32'd0);
      check("add_sign", {31'd0, Sign}, 32'd0);
      tick(4);
      check("add_x1", dut.u_rf.regs[1], 32'd5);

      drive(r_ins(4, 2, 3), 1, 0, ALU_SUB, 0, 0, 0, 0);
      check("sub_sign", {31'd0, Sign}, 32'd1);
      tick(4);
      check("sub_x4", dut.u_rf.regs[4], 32'hFFFF_FFFF);

      drive(r_ins(8, 2, 3), 1, 0, ALU_SLT, 0, 0, 0, 0);
      tick(4);
      check("slt_x8", dut.u_rf.regs[8], 32'd1);

      drive(r_ins(17, 4, 3), 1, 0, ALU_SLTU, 0, 0, 0, 0);
      tick(4);
      check("sltu_x17", dut.u_rf.regs[17], 32'd0);

      drive(s_ins(2, 1, 12'd20), 0, 1, ALU_ADD, 1, 0, 0, 0);
      tick(4);
      check("sw_mem5", dut.dmem[5], 32'd5);

      drive(i_ins(OP_LOAD, 14, 2, 12'd20), 1, 1, ALU_ADD, 0, 1, 1, 0);
      tick(4);
      check("lw_x14", dut.u_rf.regs[14], 32'd5);

      drive(i_ins(OP_LOAD, 14, 2, 12'd20), 1, 1, ALU_ADD, 0, 0, 1, 0);
      tick(4);
      check("lw_noread", dut.u_rf.regs[14], 32'd0);

      // load and store to word 5 together: rs2 field of this word is x20
      drive(i_ins(OP_LOAD, 14, 2, 12'd20), 1, 1, ALU_ADD, 1, 1, 1, 0);
      tick(4);
      check("rw_old", dut.u_rf.regs[14], 32'd5);
      check("rw_mem5", dut.dmem[5], 32'd20);

      drive(u_ins(22, 20'd21), 1, 1, ALU_LUI, 0, 0, 0, 0);
      tick(4);
      check("lui_x22", dut.u_rf.regs[22], 32'h0001_5000);

      drive(r_ins(9, 3, 6), 1, 0, ALU_XOR, 0, 0, 0, 0);
      tick(4);
      check("xor_x9", dut.u_rf.regs[9], 32'd5);

      drive(r_ins(10, 3, 2), 1, 0, ALU_SLL, 0, 0, 0, 0);
      tick(4);
      check("sll_x10", dut.u_rf.regs[10], 32'd12);

      drive(r_ins(11, 4, 2), 1, 0, ALU_SRL, 0, 0, 0, 0);
      tick(4);
      check("srl_x11", dut.u_rf.regs[11], 32'h3FFF_FFFF);

      drive(r_ins(15, 3, 6), 1, 0, 4'd12, 0, 0, 0, 0);
      check("op12_zero", {31'd0, Zero}, 32'd1);
      tick(4);
      check("op12_x15", dut.u_rf.regs[15], 32'd0);

      drive(i_ins(OP_I, 0, 2, 12'd20), 1, 1, ALU_ADD, 0, 0, 0, 0);
      tick(4);
      check("addi_x0", dut.u_rf.regs[0], 32'd0);

      drive(b_ins(5, 2, 13'd20), 0, 0, ALU_SUB, 0, 0, 0, 1);
      check("beq_nt_zero", {31'd0, Zero}, 32'd0);
      tick(4);

      drive(b_ins(2, 2, 13'd20), 0, 0, ALU_SUB, 0, 0, 0, 1);
      check("beq_t_zero", {31'd0, Zero}, 32'd1);
      tick(20);
      check("beq_t_pc80", dut.pc, 32'd80);

      drive(32'h0, 0, 0, 4'd0, 0, 0, 0, 0);
      #2;
      ResetPC = 1'b0;
      #1;
      check("midrst_pc", dut.pc, 32'd0);
      check("midrst_x1", dut.u_rf.regs[1], 32'd1);
      check("midrst_x4", dut.u_rf.regs[4], 32'd4);
      @(negedge CLK);
      ResetPC = 1'b1;
      exp_pc = 0;

      drive(r_ins(1, 3, 2), 1, 0, ALU_ADD, 0, 0, 0, 0);
      tick(4);
      check("add2_x1", dut.u_rf.regs[1], 32'd5);
      drive(32'h0, 0, 0, 4'd0, 0, 0, 0, 0);
      #2;
      ResetPC = 1'b0;
      #2;
      ResetPC = 1'b1;
      #1;
      check("pulse_x1", dut.u_rf.regs[1], 32'd1);
      check("pulse_pc", dut.pc, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
